// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO in front of it, used to return
// results from the miner core to the host. Contains the generic byte FIFO and
// the transmitter top.

// sync_fifo: generic single-clock FIFO with occupancy count and pop strobe.
// Latency: a written entry is visible at rd_dat the cycle after the write edge.
// Backpressure: wr_rdy low while full; writes while full are dropped, pops while empty ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    input  logic                     rd_pop,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance depends only on the registered count, so a write while full
    // is dropped even when a pop frees a slot on the same edge.
    assign wr_rdy = (count != FULL);
    assign wr_acc = wr_vld && wr_rdy;
    assign rd_acc = rd_pop && (count != '0);
    assign rd_dat = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge i_Clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// uart_tx_fifo: queues bytes and sends each as an 8N1 frame (start, 8 data LSB first, stop).
// Latency: byte written at edge N into an idle empty queue drives the start bit from edge N+2.
// Backpressure: o_Tx_Ready low while the queue is full; writes while full are silently dropped.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    localparam logic [12:0] BIT_LAST = 13'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [12:0] bit_cnt;
    logic [12:0] bit_cnt_nxt;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_nxt;
    logic [7:0]  shift;
    logic [7:0]  head_dat;
    logic        serial_nxt;
    logic        pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .wr_vld  (i_Tx_DV),
        .wr_dat  (i_Tx_Byte),
        .wr_rdy  (o_Tx_Ready),
        .rd_pop  (pop),
        .rd_dat  (head_dat),
        .count   (o_Fifo_Count)
    );

    // Next-state, bit timing and line value; the line itself is registered below.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        serial_nxt  = 1'b1;
        o_Tx_Active = 1'b0;
        o_Tx_Done   = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (o_Fifo_Count != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                serial_nxt  = 1'b0;
                o_Tx_Active = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + 13'd1;
                end
            end
            DATA: begin
                serial_nxt  = shift[bit_idx];
                o_Tx_Active = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 13'd1;
                end
            end
            STOP: begin
                o_Tx_Active = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = CLEANUP;
                end else begin
                    bit_cnt_nxt = bit_cnt + 13'd1;
                end
            end
            CLEANUP: begin
                o_Tx_Done   = 1'b1;
                bit_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
            default: begin
                bit_cnt_nxt = '0;
                bit_idx_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end

    // State, counters, shift register (loaded only on pop) and the registered line.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_Tx_Serial <= 1'b1;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            o_Tx_Serial <= serial_nxt;
            if (pop) begin
                shift <= head_dat;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-timeline model plus directed vectors, and a
// second instance at the minimum bit period.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FL    = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic ready, serial, active, done;
    logic [2:0] count;

    logic dv2 = 1'b0;
    logic [7:0] tx_byte2 = 8'h00;
    logic ready2, serial2, active2, done2;
    logic [2:0] count2;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [7:0] rx_q[$];
    int gap_q[$];

    // model state: queued bytes, frame phase (-1 idle, 0..FL-1 frame, FL cleanup)
    logic [7:0] mq[$];
    int ph = -1;
    logic [7:0] mcur = 8'h00;
    logic m_serial = 1'b1;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(ready), .o_Fifo_Count(count), .o_Tx_Serial(serial),
        .o_Tx_Active(active), .o_Tx_Done(done));

    uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(tx_byte2),
        .o_Tx_Ready(ready2), .o_Fifo_Count(count2), .o_Tx_Serial(serial2),
        .o_Tx_Active(active2), .o_Tx_Done(done2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame position derived from cycles elapsed since the pop edge.
    initial begin
        forever begin
            int pos;
            logic acc, pp;
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                ph = -1;
                m_serial = 1'b1;
            end else begin
                if (ph >= 0 && ph < FL) begin
                    pos = ph / CPB;
                    if (pos == 0) m_serial = 1'b0;
                    else if (pos == 9) m_serial = 1'b1;
                    else m_serial = mcur[3'(pos - 1)];
                end else begin
                    m_serial = 1'b1;
                end
                acc = dv && (mq.size() != DEPTH);
                pp  = (ph < 0) && (mq.size() != 0);
                if (pp) begin
                    mcur = mq.pop_front();
                    ph = 0;
                end else if (ph >= 0) begin
                    ph++;
                    if (ph > FL) ph = -1;
                end
                if (acc) mq.push_back(tx_byte);
            end
        end
    end

    // Compare DUT outputs with the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("model serial", 32'(serial), 32'(m_serial));
            chk("model active", 32'(active), 32'(ph >= 0 && ph < FL));
            chk("model done",   32'(done),   32'(ph == FL));
            chk("model count",  32'(count),  32'(mq.size()));
            chk("model ready",  32'(ready),  32'(mq.size() != DEPTH));
        end
    end

    // Receiver: samples mid-bit, records each byte and the idle-high run before it.
    initial begin
        forever begin
            int run;
            logic [7:0] b;
            run = 0;
            b = 8'h00;
            @(negedge clk);
            while (serial !== 1'b0) begin
                run++;
                @(negedge clk);
            end
            for (int j = 1; j < FL; j++) begin
                @(negedge clk);
                if ((j % CPB) == (CPB / 2) && (j / CPB) >= 1 && (j / CPB) <= 8)
                    b[3'(j / CPB - 1)] = serial;
            end
            rx_q.push_back(b);
            gap_q.push_back(run);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int t = 0;
        while ((active !== 1'b0 || done !== 1'b0 || count !== 3'd0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("reach idle", 32'(active), 32'd0);
        repeat (3) @(negedge clk);
        rx_q.delete();
        gap_q.delete();
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rx frame count", 32'(rx_q.size()), 32'(n));
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] vec[4];
        int act_n;
        int base;

        // reset state
        #1 rst = 1'b1;
        #1;
        chk("reset serial", 32'(serial), 32'd1);
        chk("reset active", 32'(active), 32'd0);
        chk("reset done",   32'(done),   32'd0);
        chk("reset count",  32'(count),  32'd0);
        chk("reset ready",  32'(ready),  32'd1);
        chk("reset serial2", 32'(serial2), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // 1: single 0xA5 frame, exact waveform
        wait_idle();
        fr = {1'b1, 8'hA5, 1'b0};
        dv = 1'b1; tx_byte = 8'hA5;
        @(negedge clk);
        dv = 1'b0;
        act_n = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            chk("t1 serial", 32'(serial), 32'((k >= 2 && k <= 41) ? fr[(k - 2) / 4] : 1'b1));
            chk("t1 done", 32'(done), 32'(k == 41));
            if (active === 1'b1) act_n++;
        end
        chk("t1 active cycles", 32'(act_n), 32'd40);

        // 2: burst of 5, 6th dropped, frames in order with fixed gap
        wait_idle();
        base = done_cnt;
        for (int i = 1; i <= 5; i++) begin
            dv = 1'b1; tx_byte = 8'(i);
            @(negedge clk);
        end
        chk("t2 count full", 32'(count), 32'd4);
        chk("t2 ready low",  32'(ready), 32'd0);
        tx_byte = 8'h06;
        @(negedge clk);
        dv = 1'b0;
        chk("t2 sixth dropped", 32'(count), 32'd4);
        wait_rx(5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk("t2 rx byte", 32'(rx_q[i]), 32'(i + 1));
        for (int i = 1; i < 5 && i < gap_q.size(); i++)
            chk("t2 gap high cycles", 32'(gap_q[i] + CPB), 32'd6);
        repeat (5) @(negedge clk);
        chk("t2 done pulses", 32'(done_cnt - base), 32'd5);

        // 3: fill while active, write on the pop edge is dropped
        wait_idle();
        dv = 1'b1; tx_byte = 8'h11;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_byte = 8'h22 + 8'(i * 17);
            @(negedge clk);
        end
        dv = 1'b0;
        chk("t3 count full", 32'(count), 32'd4);
        repeat (37) @(negedge clk);
        chk("t3 cleanup done", 32'(done), 32'd1);
        @(negedge clk);
        chk("t3 idle before pop", 32'(active), 32'd0);
        dv = 1'b1; tx_byte = 8'h66;
        @(negedge clk);
        dv = 1'b0;
        chk("t3 count after pop", 32'(count), 32'd3);
        chk("t3 active after pop", 32'(active), 32'd1);
        @(negedge clk);
        chk("t3 count holds", 32'(count), 32'd3);
        wait_rx(5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk("t3 rx byte", 32'(rx_q[i]), 32'(8'h11 * (i + 1)));

        // 4: reset during data bit 3 of 0x3C with two bytes queued
        wait_idle();
        dv = 1'b1; tx_byte = 8'h3C;
        @(negedge clk);
        tx_byte = 8'h01;
        @(negedge clk);
        tx_byte = 8'h02;
        @(negedge clk);
        dv = 1'b0;
        chk("t4 queued", 32'(count), 32'd2);
        repeat (17) @(negedge clk);
        chk("t4 bit3 on line", 32'(serial), 32'd1);
        chk("t4 active", 32'(active), 32'd1);
        base = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("t4 rst serial", 32'(serial), 32'd1);
        chk("t4 rst count",  32'(count),  32'd0);
        chk("t4 rst ready",  32'(ready),  32'd1);
        chk("t4 rst active", 32'(active), 32'd0);
        chk("t4 rst done",   32'(done),   32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        act_n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (active === 1'b1) act_n++;
        end
        chk("t4 no resume", 32'(act_n), 32'd0);
        chk("t4 no done", 32'(done_cnt - base), 32'd0);

        // 5: loopback of corner bytes
        wait_idle();
        vec = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        for (int i = 0; i < 4; i++) begin
            dv = 1'b1; tx_byte = vec[i];
            @(negedge clk);
        end
        dv = 1'b0;
        wait_rx(4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++)
            chk("t5 loopback", 32'(rx_q[i]), 32'(vec[i]));

        // 6: minimum bit period, 0x80
        @(negedge clk);
        dv2 = 1'b1; tx_byte2 = 8'h80;
        @(negedge clk);
        dv2 = 1'b0;
        chk("t6 count", 32'(count2), 32'd1);
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            chk("t6 serial", 32'(serial2), 32'((k >= 2 && k <= 17) ? 1'b0 : 1'b1));
            chk("t6 active", 32'(active2), 32'(k >= 1 && k <= 20));
            chk("t6 done",   32'(done2),   32'(k == 21));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
